// File: rtl/patch_loader.sv
// Packs an 8-bit pixel byte stream into LANES-byte RAM words and writes them
// to consecutive (wrapping) addresses starting at a latched base address.

module patch_lane (
    input  logic       clk,
    input  logic       rst,
    input  logic       we,
    input  logic [7:0] d,
    output logic [7:0] q
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst)     q <= '0;
        else if (we) q <= d;
    end
endmodule

module patch_loader #(
    parameter int LANES = 12,
    parameter int AW    = 11
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [AW-1:0]      base_addr,
    input  logic [AW-1:0]      num_words,
    input  logic               s_valid,
    input  logic [7:0]         s_data,
    output logic               s_ready,
    output logic               wea,
    output logic [AW-1:0]      addra,
    output logic [8*LANES-1:0] din,
    output logic               busy,
    output logic               done
);
    localparam int            LW        = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);

    typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;

    state_t                 state, state_nxt;
    logic [AW-1:0]          base_q, num_q, word_cnt;
    logic [LW-1:0]          lane_cnt;
    logic [LANES-1:0]       lane_we;
    logic [LANES-1:0][7:0]  lane_q;
    logic                   xfer, last_xfer, start_ok, last_word;

    assign start_ok  = (state == IDLE) && start;
    assign xfer      = s_valid && s_ready;
    assign last_xfer = xfer && (lane_cnt == LAST_LANE);
    assign last_word = (word_cnt + AW'(1)) == num_q;

    always_comb begin
        state_nxt = state;
        s_ready   = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start)
                    state_nxt = (num_words == '0) ? DONE : COLLECT;
            end
            COLLECT: begin
                s_ready = 1'b1;
                if (last_xfer) state_nxt = WRITE;
            end
            WRITE:   state_nxt = last_word ? DONE : COLLECT;
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // wea/addra are loaded on the last byte so they line up with the WRITE cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            base_q   <= '0;
            num_q    <= '0;
            word_cnt <= '0;
            lane_cnt <= '0;
            wea      <= 1'b0;
            addra    <= '0;
        end else begin
            state <= state_nxt;
            wea   <= last_xfer;
            if (start_ok) begin
                base_q   <= base_addr;
                num_q    <= num_words;
                word_cnt <= '0;
                lane_cnt <= '0;
            end
            if (xfer)
                lane_cnt <= last_xfer ? '0 : lane_cnt + LW'(1);
            if (last_xfer)
                addra <= base_q + word_cnt;
            if (state == WRITE)
                word_cnt <= word_cnt + AW'(1);
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign lane_we[k] = xfer && (lane_cnt == LW'(k));
        patch_lane u_lane (
            .clk (clk),
            .rst (rst),
            .we  (lane_we[k]),
            .d   (s_data),
            .q   (lane_q[k])
        );
    end

    assign din = lane_q;
endmodule
